// File: rtl/nn_pkg.sv
// Shared types and defaults for the neural-net datapath.
// Holds the collector state encoding and the default word width.
package nn_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic {
        COLLECT,
        HOLD
    } collect_state_t;

endpackage

// File: rtl/layer_stream_collector.sv
// Serial-to-parallel collector: packs `neurons` stream words into one
// frame and presents it on a valid/ready handshake.
module layer_stream_collector
    import nn_pkg::*;
#(
    parameter int dataWidth = DATA_WIDTH,
    parameter int neurons   = 10,
    parameter int cntWidth  = $clog2(neurons + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [dataWidth-1:0]          in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [neurons*dataWidth-1:0]  out_data,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam logic [cntWidth-1:0] LAST = cntWidth'(neurons - 1);
    localparam logic [cntWidth-1:0] ONE  = cntWidth'(1);

    collect_state_t                 state, state_d;
    logic [cntWidth-1:0]            cnt, cnt_d;
    logic [neurons*dataWidth-1:0]   frame_q, frame_d;
    logic                           err_q, err_d;
    logic                           ovf_q, ovf_d;
    int                             idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= COLLECT;
            cnt     <= '0;
            frame_q <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            frame_q <= frame_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        frame_d = frame_q;
        err_d   = 1'b0;
        ovf_d   = ovf_q;
        idx     = int'(cnt);
        unique case (state)
            COLLECT: begin
                if (in_valid) begin
                    frame_d[idx*dataWidth +: dataWidth] = in_data;
                    cnt_d = cnt + ONE;
                    if (cnt == LAST) state_d = HOLD;
                end else if (cnt != '0) begin
                    cnt_d = '0;
                    err_d = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                    // Word arriving on the handshake edge starts the next frame.
                    if (in_valid) begin
                        frame_d[0 +: dataWidth] = in_data;
                        cnt_d = ONE;
                        if (neurons == 1) state_d = HOLD;
                    end
                end else if (in_valid) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign out_valid = (state == HOLD);
    assign out_data  = frame_q;
    assign frame_err = err_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_layer_stream_collector.sv
// Self-checking bench for layer_stream_collector against a
// queue-based frame model, directed scenarios plus random traffic.
module tb_layer_stream_collector;

    localparam int W = 16;
    localparam int N = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [N*W-1:0]   out_data;
    logic             frame_err;
    logic             overflow;

    int checks = 0;
    int failures = 0;

    bit         m_hold;
    logic [W-1:0] m_slots [N];
    logic [W-1:0] m_part [$];
    bit         m_err;
    bit         m_ovf;

    logic [N*W-1:0] saved;

    always #5 clk = ~clk;

    layer_stream_collector #(
        .dataWidth(W),
        .neurons  (N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    function automatic logic [N*W-1:0] m_vec();
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = m_slots[k];
        return v;
    endfunction

    task automatic m_reset();
        m_hold = 0;
        m_err  = 0;
        m_ovf  = 0;
        m_part.delete();
        for (int k = 0; k < N; k++) m_slots[k] = '0;
    endtask

    task automatic m_step(input logic v, input logic [W-1:0] d,
                          input logic r);
        m_err = 0;
        if (m_hold) begin
            if (r) begin
                m_hold = 0;
                m_part.delete();
                if (v) begin
                    m_slots[0] = d;
                    m_part.push_back(d);
                end
            end else if (v) begin
                m_ovf = 1;
            end
        end else if (v) begin
            m_slots[m_part.size()] = d;
            m_part.push_back(d);
            if (m_part.size() == N) begin
                m_hold = 1;
                m_part.delete();
            end
        end else if (m_part.size() > 0) begin
            m_err = 1;
            m_part.delete();
        end
    endtask

    task automatic chk(input string tag, input logic [N*W-1:0] got,
                       input logic [N*W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".valid"}, N*W'(out_valid), N*W'(m_hold));
        chk({tag, ".data"}, out_data, m_vec());
        chk({tag, ".err"}, N*W'(frame_err), N*W'(m_err));
        chk({tag, ".ovf"}, N*W'(overflow), N*W'(m_ovf));
    endtask

    task automatic cyc(input string tag, input logic v,
                       input logic [W-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        m_step(v, d, r);
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic burst(input string tag, input logic [W-1:0] base,
                         input int len, input logic r);
        for (int i = 0; i < len; i++) cyc(tag, 1'b1, base + W'(i), r);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        #1;
        chk_all("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        chk_all("reset");
        rst_n = 1'b1;
        cyc("idle", 1'b0, '0, 1'b0);

        // 1: full burst, consumer ready
        burst("t1", 16'd1, N, 1'b1);
        chk("t1.v1", N*W'(out_valid), N*W'(1));
        chk("t1.s0", N*W'(out_data[0 +: W]), N*W'(16'd1));
        chk("t1.s9", N*W'(out_data[144 +: W]), N*W'(16'd10));
        cyc("t1.hs", 1'b0, '0, 1'b1);
        chk("t1.v0", N*W'(out_valid), '0);

        // 2: consumer stalls 5 cycles
        burst("t2", 16'd1, N, 1'b0);
        saved = out_data;
        for (int i = 0; i < 5; i++) begin
            cyc("t2.hold", 1'b0, '0, 1'b0);
            chk("t2.const", out_data, saved);
        end
        cyc("t2.hs", 1'b0, '0, 1'b1);

        // 3: broken burst then full burst
        burst("t3.part", 16'h30, 4, 1'b0);
        cyc("t3.brk", 1'b0, '0, 1'b0);
        chk("t3.err", N*W'(frame_err), N*W'(1));
        cyc("t3.gap", 1'b0, '0, 1'b0);
        chk("t3.err0", N*W'(frame_err), '0);
        burst("t3.full", 16'h11, N, 1'b0);
        chk("t3.s0", N*W'(out_data[0 +: W]), N*W'(16'h11));
        cyc("t3.hs", 1'b0, '0, 1'b1);

        // 4: overflow while held
        burst("t4", 16'h40, N, 1'b0);
        saved = out_data;
        burst("t4.ovf", 16'hEE, 3, 1'b0);
        chk("t4.ovf", N*W'(overflow), N*W'(1));
        chk("t4.data", out_data, saved);
        cyc("t4.hs", 1'b0, '0, 1'b1);
        chk("t4.sticky", N*W'(overflow), N*W'(1));

        // 5: back-to-back, frame 2 word 0 on the handshake edge
        burst("t5.f1", 16'h100, N, 1'b1);
        chk("t5.f1", N*W'(out_data[0 +: W]), N*W'(16'h100));
        burst("t5.f2", 16'h200, N, 1'b1);
        chk("t5.f2s0", N*W'(out_data[0 +: W]), N*W'(16'h200));
        chk("t5.f2s9", N*W'(out_data[144 +: W]), N*W'(16'h209));
        cyc("t5.hs", 1'b0, '0, 1'b1);

        // 6: reset mid-burst and mid-hold
        burst("t6.a", 16'h60, 6, 1'b0);
        do_reset();
        burst("t6.b", 16'h70, N, 1'b0);
        cyc("t6.hold", 1'b0, '0, 1'b0);
        do_reset();
        chk("t6.v", N*W'(out_valid), '0);
        burst("t6.c", 16'h80, N, 1'b1);
        chk("t6.s0", N*W'(out_data[0 +: W]), N*W'(16'h80));
        cyc("t6.hs", 1'b0, '0, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rand", ($urandom_range(0, 9) != 0),
                W'($urandom), ($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
